// File: rtl/hdl_decoder_pkg.sv
// Shared types and helpers for the registered scan decoder.
// State encoding, select-to-one-hot helper and the mode input encoding.
package hdl_decoder_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDirect = 2'd1,
        StScan   = 2'd2
    } state_t;

    // Mode input encoding.
    localparam logic ModeDirect = 1'b0;
    localparam logic ModeScan   = 1'b1;

    // Widest select the one-hot helper covers; callers truncate to their own width.
    localparam int unsigned MaxSelW = 8;
    localparam int unsigned MaxOutW = 1 << MaxSelW;

    function automatic logic [MaxOutW-1:0] onehot(input logic [MaxSelW-1:0] index);
        logic [MaxOutW-1:0] v;
        v        = '0;
        v[index] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/hdl_dwell_counter.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while run is high and
// flags the last cycle of each dwell with tick. clear has priority over run.
module hdl_dwell_counter #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CntW-1:0] Last = CntW'(DWELL - 1);

    logic [CntW-1:0] cnt_q;

    // Count through the dwell, restarting on clear or after the last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
        end
    end

    assign tick = (cnt_q == Last);

endmodule

// File: rtl/hdl_scan_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with direct and scan modes.
// Scan mode (dwell counter, wrap pulse) exists only when HDL_SCAN_DECODER_SCAN_EN
// is defined; otherwise mode is ignored and only IDLE/DIRECT are reachable.
// SEL_W is limited to hdl_decoder_pkg::MaxSelW.
module hdl_scan_decoder
    import hdl_decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    load,
    input  logic [SEL_W-1:0]        sel,
    output logic [(1<<SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]        idx,
    output logic                    wrap
);

    localparam int unsigned OUT_W = 1 << SEL_W;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_d;
    logic [OUT_W-1:0] y_d;
    logic             wrap_d;
    logic             scan_req;
    logic             advance;
    logic             tick;

`ifdef HDL_SCAN_DECODER_SCAN_EN
    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(OUT_W - 1);

    assign scan_req = (mode == ModeScan);

    // Counter only runs while scanning undisturbed, so every entry into a
    // dwell (mode switch, load) starts from zero.
    hdl_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!advance),
        .run   (advance),
        .tick  (tick)
    );

    assign wrap_d = advance && tick && (idx == LastIdx);
`else
    logic unused_cfg;

    assign scan_req   = 1'b0;
    assign tick       = 1'b0;
    assign wrap_d     = 1'b0;
    assign unused_cfg = mode ^ (DWELL == 0);
`endif

    // Next state and index: clr > load > mode change > scan advance.
    always_comb begin
        state_d = state_q;
        idx_d   = idx;
        advance = 1'b0;
        if (clr) begin
            state_d = StIdle;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        idx_d   = sel;
                        state_d = scan_req ? StScan : StDirect;
                    end
                end
                StDirect: begin
                    if (load) begin
                        idx_d = sel;
                    end
                    if (scan_req) begin
                        state_d = StScan;
                    end
                end
                StScan: begin
                    if (load) begin
                        idx_d = sel;
                    end
                    if (!scan_req) begin
                        state_d = StDirect;
                    end else if (!load) begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                end
            endcase
            if (advance && tick) begin
                idx_d = idx + SEL_W'(1);
            end
        end
    end

    // Output decode from the next state so y lines up with idx on the same edge.
    always_comb begin
        y_d = '0;
        if (en && (state_d != StIdle)) begin
            y_d = OUT_W'(onehot(MaxSelW'(idx_d)));
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx     <= '0;
            y       <= '0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx     <= idx_d;
            y       <= y_d;
            wrap    <= wrap_d;
        end
    end

endmodule

// File: tb/tb_hdl_scan_decoder.sv
// Self-checking bench for hdl_scan_decoder (SEL_W=2, DWELL=2).
// Expected outputs come from a small behavioural model and are queued per cycle.
module tb_hdl_scan_decoder;

    localparam int unsigned SEL_W = 2;
    localparam int unsigned DWELL = 2;
    localparam int unsigned OUT_W = 1 << SEL_W;
`ifdef HDL_SCAN_DECODER_SCAN_EN
    localparam bit ScanEn = 1'b1;
`else
    localparam bit ScanEn = 1'b0;
`endif

    typedef struct packed {
        logic [OUT_W-1:0] y;
        logic [SEL_W-1:0] idx;
        logic             wrap;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             en = 1'b1;
    logic             mode = 1'b0;
    logic             load = 1'b0;
    logic [SEL_W-1:0] sel = '0;
    logic [OUT_W-1:0] y;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb[$];

    // Model state: 0 idle, 1 direct, 2 scan.
    int m_st = 0;
    int m_idx = 0;
    int m_cnt = 0;
    int m_wrap = 0;
    int m_y = 0;

    hdl_scan_decoder #(
        .SEL_W (SEL_W),
        .DWELL (DWELL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .mode  (mode),
        .load  (load),
        .sel   (sel),
        .y     (y),
        .idx   (idx),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_idx = 0; m_cnt = 0; m_wrap = 0; m_y = 0;
    endtask

    task automatic model_edge(input logic ld, input int s, input logic md, input logic e,
                              input logic c);
        bit scan;
        scan   = ScanEn && md;
        m_wrap = 0;
        if (c) begin
            m_st = 0; m_idx = 0; m_cnt = 0;
        end else if (ld) begin
            m_idx = s;
            m_cnt = 0;
            m_st  = scan ? 2 : 1;
        end else if (m_st == 1 && scan) begin
            m_st = 2; m_cnt = 0;
        end else if (m_st == 2 && !scan) begin
            m_st = 1;
        end else if (m_st == 2) begin
            if (m_cnt == DWELL - 1) begin
                m_cnt = 0;
                if (m_idx == OUT_W - 1) m_wrap = 1;
                m_idx = (m_idx + 1) % OUT_W;
            end else begin
                m_cnt++;
            end
        end
        m_y = (e && m_st != 0) ? (1 << m_idx) : 0;
    endtask

    // One clock: drive at negedge, queue the model's prediction, compare after posedge.
    task automatic step(input string tag, input logic ld, input int s, input logic md,
                        input logic e, input logic c);
        exp_t ex;
        exp_t want;
        @(negedge clk);
        load = ld; sel = SEL_W'(s); mode = md; en = e; clr = c;
        model_edge(ld, s, md, e, c);
        ex.y    = OUT_W'(m_y);
        ex.idx  = SEL_W'(m_idx);
        ex.wrap = (m_wrap != 0);
        sb.push_back(ex);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        check({tag, ".y"}, 32'(y), 32'(want.y));
        check({tag, ".idx"}, 32'(idx), 32'(want.idx));
        check({tag, ".wrap"}, 32'(wrap), 32'(want.wrap));
        load = 1'b0;
        clr  = 1'b0;
    endtask

    initial begin
        int wraps;
        logic [OUT_W-1:0] seq [9];
        seq[0] = 4'b0001; seq[1] = 4'b0001; seq[2] = 4'b0010; seq[3] = 4'b0010;
        seq[4] = 4'b0100; seq[5] = 4'b0100; seq[6] = 4'b1000; seq[7] = 4'b1000;
        seq[8] = 4'b0001;

        // Reset values.
        #1;
        check("rst.y", 32'(y), 0);
        check("rst.idx", 32'(idx), 0);
        check("rst.wrap", 32'(wrap), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("idle", 0, 0, 0, 1, 0);

        // Direct mode.
        step("ld2", 1, 2, 0, 1, 0);
        check("ld2.lit", 32'(y), 32'h4);
        step("ld0", 1, 0, 0, 1, 0);
        check("ld0.lit", 32'(y), 32'h1);
        step("hold0", 0, 0, 0, 1, 0);

        // Enable gating at idx 3.
        step("ld3", 1, 3, 0, 1, 0);
        step("en0", 0, 0, 0, 0, 0);
        check("en0.lit", 32'(y), 0);
        check("en0.idx", 32'(idx), 3);
        step("en1", 0, 0, 0, 1, 0);
        check("en1.lit", 32'(y), 32'h8);

        // clr to idle; clr beats a simultaneous load.
        step("clrld", 1, 2, 0, 1, 1);
        check("clr.lit", 32'(y), 0);

`ifdef HDL_SCAN_DECODER_SCAN_EN
        // Full scan period with a single wrap on the return to 0001.
        wraps = 0;
        for (int i = 0; i < 9; i++) begin
            step("scan", (i == 0), 0, 1, 1, 0);
            check("scan.seq", 32'(y), 32'(seq[i]));
            if (wrap) wraps++;
        end
        check("scan.wrapcnt", 32'(wraps), 1);
        check("scan.wraplast", 32'(wrap), 1);

        // Walk to idx 3, then reload sel=1 mid-dwell.
        for (int i = 0; i < 7; i++) step("walk", 0, 0, 1, 1, 0);
        check("walk.idx", 32'(idx), 3);
        step("ldscan", 1, 1, 1, 1, 0);
        check("ldscan.y", 32'(y), 32'h2);
        check("ldscan.wrap", 32'(wrap), 0);
        step("ldscan2", 0, 0, 1, 1, 0);
        check("ldscan2.y", 32'(y), 32'h2);
        step("ldscan3", 0, 0, 1, 1, 0);
        check("ldscan3.y", 32'(y), 32'h4);

        // Mode back to direct freezes idx; mode+load switches with new idx.
        step("freeze", 0, 0, 0, 1, 0);
        step("frz2", 0, 0, 0, 1, 0);
        step("toscan", 1, 3, 1, 1, 0);
        step("sc1", 0, 0, 1, 1, 0);

        // clr mid-scan.
        step("clrscan", 0, 0, 1, 1, 1);
        check("clrscan.y", 32'(y), 0);
        check("clrscan.idx", 32'(idx), 0);
        step("postclr", 0, 0, 1, 1, 0);
        check("postclr.y", 32'(y), 0);

        // Back into scan for the async reset check.
        step("rescan", 1, 2, 1, 1, 0);
        step("rescan2", 0, 0, 1, 1, 0);
        step("rescan3", 0, 0, 1, 1, 0);
`else
        // Mode ignored: y holds 1000 and wrap never fires.
        wraps = 0;
        for (int i = 0; i < 12; i++) begin
            step("nscan", (i == 0), 3, 1, 1, 0);
            check("nscan.y", 32'(y), 32'h8);
            if (wrap) wraps++;
        end
        check("nscan.wrapcnt", 32'(wraps), 0);
        check("nscan.seq0", 32'(seq[0]), 32'(seq[8]));
`endif

        // Asynchronous reset away from any clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.y", 32'(y), 0);
        check("arst.idx", 32'(idx), 0);
        check("arst.wrap", 32'(wrap), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("arst.hold", 0, 0, 1, 1, 0);
        step("arst.hold2", 0, 0, 0, 1, 0);

        // Randomised mix against the model.
        for (int i = 0; i < 300; i++) begin
            step("rnd",
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, OUT_W - 1)),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 29) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
